// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store front end for the dmem_ext byte-lane data memory.
//
// It accepts byte-addressed load/store requests over a valid/ready handshake.
// It drives the memory strobes, the lane enables, the word address and the
// lane-positioned data. Loads are lane-aligned and then sign- or zero-extended.
// An access that crosses a word boundary becomes two word transactions, and
// the two results are merged. Each request gets exactly one response.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_store, req_size,       request: store flag, size (0=B 1=H 2=W 3=illegal),
//   req_unsigned, req_addr,    zero-extend flag, byte address,
//   req_wdata                  right-justified store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_store,      response: extended load data, store echo,
//   rsp_err                    illegal-size flag
//   mem_valid_st, mem_spec_ld  memory store / load strobes
//   mem_we, mem_addr, mem_din  lane enables, word address, store data
//   mem_dout                   memory read data (one cycle after mem_spec_ld)
module dmem_lsu #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_store,
   output logic                  rsp_err,
   output logic                  mem_valid_st,
   output logic                  mem_spec_ld,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);

   typedef enum logic [1:0] {IDLE, LD1, LD2, ST2} state_t;

   // The size's byte ones are shifted into an 8-lane window.
   // Bits [3:0] are the lanes of the first word and bits [7:4] are the lanes
   // of the next word. The access is split whenever the upper nibble is nonzero.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] ones;
      case (size)
         2'd0:    ones = 4'b0001;
         2'd1:    ones = 4'b0011;
         default: ones = 4'b1111;
      endcase
      return {4'b0000, ones} << off;
   endfunction

   // src holds {second word, first word}. For an unsplit load the upper half is zero.
   function automatic logic [31:0] fmt(input logic [63:0] src, input logic [1:0] off,
                                       input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      sh = 32'(src >> {off, 3'b000});
      case (size)
         2'd0:    return {{24{~uns & sh[7]}}, sh[7:0]};
         2'd1:    return {{16{~uns & sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   state_t                state_q, state_d;
   logic [1:0]            off_q, off_d, size_q, size_d;
   logic                  uns_q, uns_d, split_q, split_d;
   logic [ADDR_WIDTH-1:0] wa_q, wa_d;
   logic [31:0]           wdata_q, wdata_d, hold_q, hold_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_store_q, rsp_store_d, rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;

   logic [1:0]            req_off;
   logic [ADDR_WIDTH-1:0] req_wa, wa_next;
   logic [7:0]            req_mask, ctx_mask;
   logic                  accept;

   assign req_off  = req_addr[1:0];
   assign req_wa   = req_addr[ADDR_WIDTH+1:2];
   assign req_mask = lane_mask(req_size, req_off);
   assign ctx_mask = lane_mask(size_q, off_q);
   assign wa_next  = wa_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};   // wraps to 0

   assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_store = rsp_store_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      split_d      = split_q;
      wa_d         = wa_q;
      wdata_d      = wdata_q;
      hold_d       = hold_q;
      rsp_valid_d  = rsp_valid_q && !rsp_ready;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_store_d  = rsp_store_q;
      rsp_err_d    = rsp_err_q;
      mem_valid_st = 1'b0;
      mem_spec_ld  = 1'b0;
      mem_we       = 4'b0000;
      mem_addr     = '0;
      mem_din      = 32'h0;

      case (state_q)
         IDLE: if (accept) begin
            off_d   = req_off;
            size_d  = req_size;
            uns_d   = req_unsigned;
            split_d = |req_mask[7:4];
            wa_d    = req_wa;
            wdata_d = req_wdata;
            if (req_size == 2'd3) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'h0;
               rsp_store_d = req_store;
               rsp_err_d   = 1'b1;
            end else if (req_store) begin
               mem_valid_st = 1'b1;
               mem_addr     = req_wa;
               mem_we       = req_mask[3:0];
               mem_din      = req_wdata << {req_off, 3'b000};
               if (|req_mask[7:4]) begin
                  state_d = ST2;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'h0;
                  rsp_store_d = 1'b1;
                  rsp_err_d   = 1'b0;
               end
            end else begin
               mem_spec_ld = 1'b1;
               mem_addr    = req_wa;
               state_d     = LD1;
            end
         end
         LD1: begin
            if (split_q) begin
               hold_d      = mem_dout;
               mem_spec_ld = 1'b1;
               mem_addr    = wa_next;
               state_d     = LD2;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = fmt({32'h0, mem_dout}, off_q, size_q, uns_q);
               rsp_store_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         LD2: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fmt({mem_dout, hold_q}, off_q, size_q, uns_q);
            rsp_store_d = 1'b0;
            rsp_err_d   = 1'b0;
            state_d     = IDLE;
         end
         ST2: begin
            // Spilled lanes land at the bottom of the next word.
            mem_valid_st = 1'b1;
            mem_addr     = wa_next;
            mem_we       = ctx_mask[7:4];
            mem_din      = wdata_q >> {3'd4 - {1'b0, off_q}, 3'b000};
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = 32'h0;
            rsp_store_d  = 1'b1;
            rsp_err_d    = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         off_q       <= 2'd0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         split_q     <= 1'b0;
         wa_q        <= '0;
         wdata_q     <= 32'h0;
         hold_q      <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_store_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         split_q     <= split_d;
         wa_q        <= wa_d;
         wdata_q     <= wdata_d;
         hold_q      <= hold_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_store_q <= rsp_store_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
